// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, message-locking arbiter sharing one UART transmitter.
// Optional macro UART_TX_ARB_CRLF_EN expands each accepted 0x0A into 0x0D then 0x0A.
module uart_tx_arbiter #(
  parameter  int NUM_REQ      = 4,
  parameter  int LOCK_TIMEOUT = 1024,
  localparam int ID_W         = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_enable,
  input  logic                 tx_busy,
  output logic [ID_W-1:0]      grant_id,
  output logic                 lock_active,
  output logic                 arb_busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

  localparam int TMO_W = (LOCK_TIMEOUT > 2) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_MAX = (LOCK_TIMEOUT > 0) ? TMO_W'(LOCK_TIMEOUT - 1) : '0;

  state_t            state_q;
  logic [7:0]        hold_q;
  logic              tx_enable_q;
  logic [ID_W-1:0]   grant_q;
  logic [ID_W-1:0]   rr_q;
  logic [ID_W-1:0]   owner_q;
  logic              lock_q;
  logic [TMO_W-1:0]  tmo_q;

  logic [ID_W-1:0]   pick;
  logic              pick_vld;
  logic              accept;
  logic [7:0]        pick_byte;

  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s -= NUM_REQ;
    return ID_W'(s);
  endfunction

  // Scan downward so the requester closest to the rr pointer overrides the rest.
  always_comb begin
    pick     = owner_q;
    pick_vld = 1'b0;
    if (lock_q) begin
      pick_vld = req_valid[owner_q];
    end else begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        if (req_valid[wrap_add(rr_q, k)]) begin
          pick     = wrap_add(rr_q, k);
          pick_vld = 1'b1;
        end
      end
    end
  end

  assign accept    = !reset && (state_q == IDLE) && pick_vld && !tx_busy;
  assign pick_byte = req_data[{pick, 3'b000} +: 8];

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[pick] = 1'b1;
  end

`ifdef UART_TX_ARB_CRLF_EN
  logic pending_q;
  assign tx_data = pending_q ? 8'h0D : hold_q;
`else
  assign tx_data = hold_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_q      <= 8'h00;
      tx_enable_q <= 1'b0;
      grant_q     <= '0;
      rr_q        <= '0;
      owner_q     <= '0;
      lock_q      <= 1'b0;
      tmo_q       <= '0;
`ifdef UART_TX_ARB_CRLF_EN
      pending_q   <= 1'b0;
`endif
    end else begin
      tx_enable_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            hold_q      <= pick_byte;
            grant_q     <= pick;
            tx_enable_q <= 1'b1;
            tmo_q       <= '0;
            state_q     <= ISSUE;
`ifdef UART_TX_ARB_CRLF_EN
            pending_q   <= (pick_byte == 8'h0A);
`endif
            if (req_last[pick]) begin
              lock_q <= 1'b0;
              rr_q   <= wrap_add(pick, 1);
            end else begin
              lock_q  <= 1'b1;
              owner_q <= pick;
            end
          end else if (LOCK_TIMEOUT > 0 && lock_q && !req_valid[owner_q]) begin
            if (tmo_q == TMO_MAX) begin
              lock_q <= 1'b0;
              rr_q   <= wrap_add(owner_q, 1);
              tmo_q  <= '0;
            end else begin
              tmo_q <= tmo_q + 1'b1;
            end
          end
        end
        ISSUE:    state_q <= WAIT_ACK;
        WAIT_ACK: if (tx_busy) state_q <= WAIT_DONE;
        WAIT_DONE: begin
          if (!tx_busy) begin
`ifdef UART_TX_ARB_CRLF_EN
            if (pending_q) begin
              pending_q   <= 1'b0;
              tx_enable_q <= 1'b1;
              state_q     <= ISSUE;
            end else begin
              state_q <= IDLE;
            end
`else
            state_q <= IDLE;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_enable   = tx_enable_q;
  assign grant_id    = grant_q;
  assign lock_active = lock_q;
  assign arb_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_enable;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        lock_active;
  logic        arb_busy;

  uart_tx_arbiter #(.NUM_REQ(4), .LOCK_TIMEOUT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .tx_data    (tx_data),
    .tx_enable  (tx_enable),
    .tx_busy    (tx_busy),
    .grant_id   (grant_id),
    .lock_active(lock_active),
    .arb_busy   (arb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int bcnt    = 0;
  int busy_len = 3;

  logic [8:0] qmem [4][16];
  int         qh [4];
  int         qt [4];

  logic [7:0] sent[$];
  int         sent_cyc[$];
  int         glog[$];
  logic       llog[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    qmem[r][qt[r]] = {l, d};
    qt[r]++;
  endtask

  function automatic bit queues_empty();
    for (int i = 0; i < 4; i++) if (qh[i] != qt[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_logs();
    sent.delete(); sent_cyc.delete(); glog.delete(); llog.delete();
  endtask

  // One clock: drive queue heads, sample at negedge, advance transmitter model after the edge.
  task automatic step();
    logic [3:0] hs;
    logic       en;
    for (int i = 0; i < 4; i++) begin
      if (qh[i] != qt[i]) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = qmem[i][qh[i]][7:0];
        req_last[i]        = qmem[i][qh[i]][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
    @(negedge clk);
    hs = req_valid & req_ready;
    en = tx_enable;
    if (en) begin
      sent.push_back(tx_data);
      sent_cyc.push_back(cyc);
    end
    for (int i = 0; i < 4; i++) if (hs[i]) glog.push_back(i);
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++) if (hs[i]) qh[i]++;
    if (hs != 4'b0000) llog.push_back(lock_active);
    if (en) bcnt = busy_len;
    else if (bcnt > 0) bcnt--;
    tx_busy = (bcnt != 0);
  endtask

  task automatic run_idle(input string tag);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 500 && !done; n++) begin
      step();
      done = queues_empty() && !arb_busy && (bcnt == 0);
    end
    check(tag, done, 1);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    bcnt      = 0;
    tx_busy   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      qh[i] = 0;
      qt[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    clear_logs();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int sp;
    reset     = 1'b1;
    req_valid = 4'hF;
    req_data  = 32'hFFFF_FFFF;
    req_last  = 4'h0;
    tx_busy   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      qh[i] = 0;
      qt[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx_enable", tx_enable, 0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_req_ready", req_ready, 4'h0);
    check("rst_grant_id", grant_id, 0);
    check("rst_lock", lock_active, 0);
    check("rst_arb_busy", arb_busy, 0);

    // Single byte, then rr pointer must start at 1
    do_reset();
    busy_len = 3;
    push(0, 8'h41, 1'b1);
    run_idle("single_run");
    check("single_count", sent.size(), 1);
    check("single_data", sent[0], 8'h41);
    check("single_grant", grant_id, 0);
    check("single_arb_busy", arb_busy, 0);
    clear_logs();
    push(0, 8'h42, 1'b1);
    push(1, 8'h43, 1'b1);
    run_idle("rrptr_run");
    check("rrptr_first", glog[0], 1);
    check("rrptr_second", glog[1], 0);

    // Round robin, all four valid
    do_reset();
    push(0, 8'hA0, 1'b1); push(0, 8'hA1, 1'b1);
    push(1, 8'hB0, 1'b1); push(2, 8'hC0, 1'b1); push(3, 8'hD0, 1'b1);
    run_idle("rr_run");
    check("rr_count", glog.size(), 5);
    check("rr_g0", glog[0], 0);
    check("rr_g1", glog[1], 1);
    check("rr_g2", glog[2], 2);
    check("rr_g3", glog[3], 3);
    check("rr_g4", glog[4], 0);
    check("rr_d1", sent[1], 8'hB0);
    check("rr_d4", sent[4], 8'hA1);
    check("rr_grant_id", grant_id, 0);

    // Message lock on requester 2 while 0 and 1 wait
    do_reset();
    push(1, 8'h10, 1'b1);
    run_idle("lock_pre");
    clear_logs();
    push(2, 8'h48, 1'b0); push(2, 8'h49, 1'b0); push(2, 8'h4A, 1'b1);
    push(0, 8'h30, 1'b1); push(1, 8'h31, 1'b1);
    run_idle("lock_run");
    check("lock_g0", glog[0], 2);
    check("lock_g1", glog[1], 2);
    check("lock_g2", glog[2], 2);
    check("lock_g3", glog[3], 0);
    check("lock_g4", glog[4], 1);
    check("lock_d0", sent[0], 8'h48);
    check("lock_d1", sent[1], 8'h49);
    check("lock_d2", sent[2], 8'h4A);
    check("lock_l0", llog[0], 1);
    check("lock_l1", llog[1], 1);
    check("lock_l2", llog[2], 0);
    check("lock_grant_id", grant_id, 1);

    // Lock timeout after 16 idle cycles
    do_reset();
    push(1, 8'h55, 1'b0);
    run_idle("tmo_pre");
    check("tmo_locked", lock_active, 1);
    clear_logs();
    push(3, 8'h66, 1'b1);
    repeat (15) step();
    check("tmo_still_locked", lock_active, 1);
    check("tmo_no_grant", glog.size(), 0);
    step();
    check("tmo_released", lock_active, 0);
    run_idle("tmo_run");
    check("tmo_grant", glog[0], 3);
    check("tmo_data", sent[0], 8'h66);

    // Handshake spacing with a 20-cycle busy transmitter
    do_reset();
    busy_len = 20;
    push(0, 8'h11, 1'b0); push(0, 8'h22, 1'b1);
    run_idle("hs_run");
    check("hs_pulses", sent.size(), 2);
    check("hs_d0", sent[0], 8'h11);
    check("hs_d1", sent[1], 8'h22);
    sp = sent_cyc[1] - sent_cyc[0];
    check("hs_spacing", (sp >= 23 && sp <= 24), 1);

    // Reset during WAIT_DONE
    do_reset();
    push(0, 8'h77, 1'b1);
    repeat (5) step();
    check("mid_busy", arb_busy, 1);
    check("mid_data", tx_data, 8'h77);
    reset   = 1'b1;
    bcnt    = 0;
    tx_busy = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_arb_busy", arb_busy, 0);
    check("mid_rst_tx_data", tx_data, 8'h00);
    check("mid_rst_enable", tx_enable, 0);
    check("mid_rst_grant", grant_id, 0);
    check("mid_rst_lock", lock_active, 0);
    reset = 1'b0;
    clear_logs();
    repeat (10) step();
    check("mid_no_pulse", sent.size(), 0);

    // Line feed handling
    do_reset();
    busy_len = 3;
    push(0, 8'h0A, 1'b1);
    run_idle("lf_run");
    check("lf_accepts", glog.size(), 1);
`ifdef UART_TX_ARB_CRLF_EN
    check("lf_pulses", sent.size(), 2);
    check("lf_d0", sent[0], 8'h0D);
    check("lf_d1", sent[1], 8'h0A);
`else
    check("lf_pulses", sent.size(), 1);
    check("lf_d0", sent[0], 8'h0A);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter among NUM_REQ byte-stream requesters. Round-robin arbitration with message locking, so multi-byte messages are never interleaved. Sequences the transmitter's tx_data/tx_enable/tx_busy interface: one enable pulse per byte, then waits for the byte to start and complete. Sits between the CPU/debug byte sources and the uart transmitter.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
LOCK_TIMEOUT, 1024, idle cycles after which a held lock is force-released; 0 = never
ID_W, $clog2(NUM_REQ), width of grant_id (localparam)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
req_last  in  NUM_REQ  byte is last of message; releases lock
req_ready  out  NUM_REQ  byte accepted when valid&ready
tx_data  out  8  byte to transmitter
tx_enable  out  1  one-cycle start pulse to transmitter
tx_busy  in  1  transmitter busy
grant_id  out  ID_W  current/last granted requester
lock_active  out  1  a requester holds the message lock
arb_busy  out  1  state != IDLE

Behaviour:
- Interface fixed: one clock clk; reset synchronous, active-high.
- Reset: state=IDLE, tx_data=0x00, tx_enable=0, req_ready=0, grant_id=0, lock_active=0, rr pointer=0, timeout counter=0, hold register=0x00.
- States: IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
- IDLE:
  - Unlocked: grant the first valid requester at or after the rr pointer, wrapping modulo NUM_REQ.
  - Locked: only the lock owner is eligible.
  - req_ready is combinational: high only for the granted requester, only in IDLE, only while tx_busy=0.
  - On accept: latch req_data into the hold register, set grant_id, go to ISSUE.
  - req_last=0 on accept: lock_active=1, owner = granted requester.
  - req_last=1 on accept: lock_active=0, rr pointer = grant+1 (wraps).
- ISSUE: tx_enable=1 for exactly this cycle, tx_data = hold register; go to WAIT_ACK.
- WAIT_ACK: stay until tx_busy=1 (the transmitter asserts busy one cycle after enable), then go to WAIT_DONE. No re-issue.
- WAIT_DONE: stay while tx_busy=1; on tx_busy=0 return to IDLE.
- Minimum spacing between enable pulses: 4 cycles plus the transmitter's busy duration.
- tx_data is registered and held stable from ISSUE until the next accept.
- Lock timeout (LOCK_TIMEOUT>0):
  - Counter increments each IDLE cycle while locked and owner req_valid=0; clears on accept or unlock.
  - At count == LOCK_TIMEOUT-1: lock_active=0 and rr pointer = owner+1 on the next edge.
- Simultaneous valids, unlocked: lowest index at or after the rr pointer wins; others see req_ready=0 and must hold their data.
- Deasserting req_valid without a handshake is allowed; nothing is consumed.
- Reset mid-transfer returns to IDLE immediately. No enable is issued after reset; the in-flight byte is abandoned.

Optional Feature:
Macro UART_TX_ARB_CRLF_EN.
- Defined: an accepted byte 0x0A is sent as 0x0D then 0x0A.
  - Hold register captures 0x0A; a pending_lf flag is set.
  - The first ISSUE sends 0x0D.
  - WAIT_DONE with pending_lf goes to ISSUE (not IDLE), clears the flag, and sends 0x0A.
  - Lock/rr updates happen at accept time as normal.
  - req_ready stays low until both bytes complete.
- Undefined: bytes pass unchanged; no pending_lf logic.

Test Plan:
- Single byte: req_valid[0]=1, data 0x41, last=1 -> one tx_enable pulse, tx_data=0x41, arb_busy low after the model drops busy, rr pointer=1.
- Round-robin: all 4 valid, last=1, with continuous data -> grant order 0,1,2,3,0; no requester granted twice in a row.
- Lock: req 2 sends 0x48,0x49 (last=0), then 0x4A (last=1) while req 0 and 1 stay valid -> bytes 48,49,4A consecutive, lock_active high until 4A is accepted, next grant 3 (or 0).
- Timeout: LOCK_TIMEOUT=16; req 1 sends one byte with last=0, then goes idle while req 3 is valid -> lock_active drops after 16 idle cycles, req 3 is granted next.
- Handshake timing: transmitter model raises busy 1 cycle after enable and holds it 20 cycles -> exactly one pulse per byte, next enable no earlier than 4 cycles after busy falls; reset asserted during WAIT_DONE -> all outputs at reset values the next cycle.
- CRLF (macro defined): send 0x0A -> two pulses with tx_data 0x0D then 0x0A; macro undefined -> one pulse, 0x0A.
